// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Widths above 64 bits are not supported by the constant helpers.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic logic is_div(op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   // Returned 64 bits wide; callers truncate to their own operand width.
   function automatic logic [63:0] most_neg(int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

   function automatic logic [63:0] all_ones(int unsigned w);
      return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue and writeback handshake between the core and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);

   logic             start_valid;
   logic             start_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs1;
   logic [WIDTH-1:0] rs2;
   logic             kill;
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] result;
   logic             busy;

   modport master (
      output start_valid, op, rs1, rs2, kill, result_ready,
      input  start_ready, result_valid, result, busy
   );

   modport slave (
      input  start_valid, op, rs1, rs2, kill, result_ready,
      output start_ready, result_valid, result, busy
   );

endinterface

// File: rtl/muldiv_step.sv
// Combinational UNROLL-bit iteration: shift-add multiply or restoring divide.
// Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient}.
module muldiv_step #(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             isDiv_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH:0]   t;

   // The divide remainder always stays below the divisor, so WIDTH bits hold it between steps.
   always_comb begin
      hi = hi_i;
      lo = lo_i;
      t  = '0;
      for (int k = 0; k < UNROLL; k++) begin
         if (isDiv_i) begin
            t  = {hi, lo[WIDTH-1]};
            lo = {lo[WIDTH-2:0], 1'b0};
            if (t >= {1'b0, b_i}) begin
               t     = t - {1'b0, b_i};
               lo[0] = 1'b1;
            end
            hi = t[WIDTH-1:0];
         end else begin
            t  = {1'b0, hi} + (lo[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
            lo = {t[0], lo[WIDTH-1:1]};
            hi = t[WIDTH:1];
         end
      end
      hi_o = hi;
      lo_o = lo;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: works on magnitudes, then fixes signs in one final cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0]    N_CNT      = CW'(N);
   localparam logic [63:0]      MOST_NEG64 = most_neg(WIDTH);
   localparam logic [63:0]      ALL_ONES64 = all_ones(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG   = MOST_NEG64[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ALL_ONES   = ALL_ONES64[WIDTH-1:0];

   state_e           state_q, state_d;
   op_e              opReg_q, opReg_d;
   logic             signA_q, signA_d;
   logic             signB_q, signB_d;
   logic             fast_q, fast_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             startReady;
   logic             accept;
   op_e              opIn;
   logic             sA, sB, fastHit;
   logic [WIDTH-1:0] magA, magB, fastVal;
   logic [WIDTH-1:0] stepHi, stepLo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] quo, rem, finVal;

   // kill wins over a simultaneous start, so nothing is latched on a flush cycle.
   assign accept = bus.start_valid && startReady && !bus.kill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = fastHit ? S_FIN : S_CALC;
         S_CALC: begin
            if (bus.kill)                state_d = S_IDLE;
            else if (count_q == CW'(1))  state_d = S_FIN;
         end
         S_FIN:  state_d = bus.kill ? S_IDLE : S_DONE;
         S_DONE: begin
            if (bus.kill)              state_d = S_IDLE;
            else if (accept)           state_d = fastHit ? S_FIN : S_CALC;
            else if (bus.result_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      startReady       = (state_q == S_IDLE) || (state_q == S_DONE && bus.result_ready);
      bus.start_ready  = startReady;
      bus.busy         = (state_q != S_IDLE);
      bus.result_valid = (state_q == S_DONE);
      bus.result       = result_q;
   end

   // MULHSU treats only rs1 as signed; MUL is treated as signed since its low word is sign-agnostic.
   always_comb begin
      opIn    = op_e'(bus.op);
      sA      = bus.rs1[WIDTH-1] && (opIn inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      sB      = bus.rs2[WIDTH-1] && (opIn inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
      magA    = sA ? -bus.rs1 : bus.rs1;
      magB    = sB ? -bus.rs2 : bus.rs2;
      fastHit = 1'b0;
      fastVal = '0;
      if (is_div(opIn) && bus.rs2 == '0) begin
         fastHit = 1'b1;
         fastVal = (opIn inside {OP_REM, OP_REMU}) ? bus.rs1 : ALL_ONES;
      end else if ((opIn == OP_DIV || opIn == OP_REM) &&
                   bus.rs1 == MOST_NEG && bus.rs2 == ALL_ONES) begin
         fastHit = 1'b1;
         fastVal = (opIn == OP_REM) ? '0 : bus.rs1;
      end
   end

   muldiv_step #(.WIDTH(WIDTH), .UNROLL(UNROLL)) u_step (
      .isDiv_i (is_div(opReg_q)),
      .hi_i    (hi_q),
      .lo_i    (lo_q),
      .b_i     (b_q),
      .hi_o    (stepHi),
      .lo_o    (stepLo)
   );

   // Fast-path results are parked in lo_q and passed through the final cycle untouched.
   always_comb begin
      prod = {hi_q, lo_q};
      if (signA_q ^ signB_q) prod = -prod;
      quo    = (signA_q ^ signB_q) ? -lo_q : lo_q;
      rem    = signA_q ? -hi_q : hi_q;
      finVal = lo_q;
      if (!fast_q) begin
         case (opReg_q)
            OP_MUL:                       finVal = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: finVal = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              finVal = quo;
            default:                      finVal = rem;
         endcase
      end
   end

   always_comb begin
      opReg_d  = opReg_q;
      signA_d  = signA_q;
      signB_d  = signB_q;
      fast_d   = fast_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      result_d = result_q;
      if (accept) begin
         opReg_d = opIn;
         signA_d = sA;
         signB_d = sB;
         fast_d  = fastHit;
         count_d = N_CNT;
         hi_d    = '0;
         b_d     = is_div(opIn) ? magB : magA;
         lo_d    = fastHit ? fastVal : (is_div(opIn) ? magA : magB);
      end else if (state_q == S_CALC) begin
         hi_d    = stepHi;
         lo_d    = stepLo;
         count_d = count_q - CW'(1);
      end
      if (state_q == S_FIN && !bus.kill) result_d = finVal;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opReg_q  <= OP_MUL;
         signA_q  <= 1'b0;
         signB_q  <= 1'b0;
         fast_q   <= 1'b0;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         opReg_q  <= opReg_d;
         signA_q  <= signA_d;
         signB_q  <= signB_d;
         fast_q   <= fast_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M-style multiply/divide execution unit, parametrised in operand width and bits retired per cycle.
- Sits beside the ALU in the next-generation core; operands come from the register file read ports and funct3 from the decoded instruction.
- Control issues via a start/ready handshake, and the result is written back via a valid/ready handshake.
- Multi-cycle, so the core stalls while the unit is busy.

Parameters:
- WIDTH, 32, operand and result width in bits (even, >= 8).
- UNROLL, 1, quotient/product bits resolved per cycle; must divide WIDTH (1, 2, 4 supported).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_valid  in  1  request an operation
- start_ready  out  1  unit can accept a request this cycle
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  in  WIDTH  operand 1 (multiplicand/dividend)
- rs2  in  WIDTH  operand 2 (multiplier/divisor)
- kill  in  1  abort the in-flight operation (pipeline flush)
- result_valid  out  1  result register holds a completed result
- result_ready  in  1  consumer takes the result
- result  out  WIDTH  result value
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE. result_valid=0, result=0, busy=0, start_ready=1. All internal accumulators are cleared.
- States: IDLE, CALC, FIN, DONE.
- Acceptance: the transfer fires when start_valid && start_ready.
  - start_ready = (state==IDLE) || (state==DONE && result_ready).
  - On the accepting edge, latch op, the operand signs and the magnitudes (signed ops take the absolute value; MULHSU treats only rs1 as signed). Load the iteration counter with N = WIDTH/UNROLL.
- Fast paths decided at acceptance; next state is FIN, with CALC skipped:
  - Divide with rs2==0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - DIV/REM with rs1 = most-negative and rs2 = all-ones: DIV gives rs1; REM gives 0.
- Normal path: next state CALC.
  - Multiply: shift-add over a 2*WIDTH accumulator, UNROLL multiplier bits per cycle.
  - Divide: restoring divide, UNROLL quotient bits per cycle, with a WIDTH+1-bit remainder.
  - Counter decrements each cycle; CALC→FIN on the edge where the counter reaches 1.
- FIN, one cycle: apply sign correction.
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
  - Select the low word (MUL, DIV*, REM*) or the high word (MULH*). Register into result; state→DONE, result_valid=1.
- Latency in edges from accept to result_valid=1: normal N+1 (33 at WIDTH=32, UNROLL=1; 9 at UNROLL=4); fast path 1.
- DONE:
  - result and result_valid are held stable until result_ready.
  - On result_ready: accept a new request in the same cycle if start_valid (back-to-back, no bubble), else go to IDLE.
  - result retains its last value after handoff.
- kill: in CALC or FIN, go to IDLE next edge with result_valid=0; no result is produced. In DONE, drop result_valid and go to IDLE. kill has priority over start in the same cycle, so no acceptance occurs. kill in IDLE has no effect.
- start_valid while not ready: ignored; no latching.
- Reset mid-operation: immediate return to reset values; no partial result is visible.
- Arithmetic is modulo 2^WIDTH, with no exceptions, as RV32M specifies.

Decomposition:
- muldiv_pkg holds:
  - op enum (MUL…REMU) and the state enum.
  - Helper function is_div(op).
  - Constants MOST_NEG(WIDTH) and ALL_ONES(WIDTH).
- Sub-module muldiv_step: combinational UNROLL-bit iteration for both shift-add and restoring-divide, instantiated once in CALC datapath.
- Top handles handshake, FSM, sign pre/post-processing.

Test Plan (WIDTH=32):
- MUL: rs1=7, rs2=0xFFFFFFFD. Result 0xFFFFFFEB with valid after exactly 33 edges (UNROLL=1). Rerun at UNROLL=4: 9 edges.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV and REM with rs1=0xFFFFFFF9 (-7), rs2=2: DIV → 0xFFFFFFFD (-3), REM → 0xFFFFFFFF (-1). DIVU 100/7 → 14; REMU 100/7 → 2.
- Fast paths, each with valid 1 edge after accept:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Handshake:
  - Hold result_ready=0 for 5 cycles in DONE: result stable, start_ready=0.
  - Then result_ready=1 with start_valid=1: new op accepted on that edge, with no IDLE cycle.
- Abort and reset:
  - kill at CALC cycle 10 → IDLE next edge, no result_valid.
  - rst asserted asynchronously mid-CALC (between edges) → outputs at reset values immediately.
  - Post-reset DIVU 9/3 → 3.
